gpif_burst_reader: RTL and testbench
====================================

# gpif_burst_reader

Synthesizable consumer for the FPGA-to-FX3 GPIF sample stream: plays the FX3 role on the 16-bit databus by watching `dataAvailable`, driving `readData` for fixed-length bursts and capturing the returned words. It sits on the `fx3_clock` domain, either facing the sampler in a loopback or bring-up build or facing a second board's GPIF pins. With the checker compiled in, it verifies the test-mode ramp (10-bit counter, zero-extended) and counts pattern and overflow errors.

## Interface
Parameters:
- `BURST_WORDS`, 8192: words read per burst; power of two, range 16..65536.
- `READ_LATENCY`, 2: cycles from a `readData`-high cycle to the matching word being valid on `databus`; range 1..4.
- `GAP_CYCLES`, 4: idle cycles between bursts; range 1..255.

Ports:
- `clock`  in  1  GPIF clock (60 MHz `fx3_clock` domain).
- `nReset`  in  1  asynchronous active-low reset.
- `enable`  in  1  1 = start and continue bursts; 0 = finish the current burst, then idle.
- `dataAvailable`  in  1  producer has at least `BURST_WORDS` words buffered.
- `bufferError`  in  1  producer overflow flag, level.
- `databus`  in  16  sample word from producer.
- `readData`  out  1  consumer is reading; one word per high cycle.
- `wordValid`  out  1  `wordOut` holds a captured word this cycle.
- `wordOut`  out  16  captured word, registered.
- `burstDone`  out  1  one-cycle pulse when the last word of a burst is captured.
- `burstCount`  out  16  completed bursts, wraps at 65535 -> 0.
- `errorCount`  out  16  pattern mismatches, saturates at 65535.
- `overflowSeen`  out  1  sticky; set when `bufferError` is sampled high.

## Operation
- States: IDLE, ARM, READ, DRAIN, GAP.
- IDLE: move to ARM when `enable`=1.
- ARM: move to READ when `dataAvailable`=1. If `enable`=0, move back to IDLE.
- READ: `readData`=1 for exactly `BURST_WORDS` consecutive cycles. The read counter is log2(`BURST_WORDS`)+1 bits. `dataAvailable` is ignored once READ is entered.
- DRAIN: hold `readData`=0 until all `READ_LATENCY` in-flight words are captured, then go to GAP.
- GAP: count `GAP_CYCLES`, then go to ARM if `enable`=1, otherwise IDLE.
- Capture: a `READ_LATENCY`-deep shift register of `readData` qualifies sampling. A qualified cycle registers `databus` into `wordOut` and sets `wordValid`=1 on the next cycle.
- `burstDone` pulses in the same cycle as `wordValid` for the last word. `burstCount` increments in that same cycle.
- `overflowSeen` is set on any cycle where `bufferError`=1, in every state. Only reset clears it.
- Dropping `enable` mid-READ does not truncate the burst.

## Timing
- Reset values: `readData`=0, `wordValid`=0, `wordOut`=0, `burstDone`=0, `burstCount`=0, `errorCount`=0, `overflowSeen`=0; state IDLE; checker unseeded.
- Reset is asynchronous and clears everything immediately, including mid-burst. The first possible `readData` comes 2 cycles after `nReset` rises with `enable`=1 and `dataAvailable`=1 (IDLE -> ARM -> READ).
- `readData` is registered. The first word is valid on `databus` at read cycle + `READ_LATENCY`. `wordValid` follows one cycle later.
- Burst period = 1 (ARM, if `dataAvailable` is already 1) + `BURST_WORDS` + `READ_LATENCY` + `GAP_CYCLES` cycles.
- Event ordering within one cycle: a pattern error in the same cycle as `burstDone` counts toward the burst just finished. If `bufferError` and reset assert together, reset wins.

## Configuration
- `GPIF_READER_CHECK_EN` defined: the ramp checker is built.
  - The first captured word after reset seeds `expected` = word[9:0]+1 mod 1024.
  - Every later word is compared with {6'b0, `expected`}.
  - On a mismatch, `errorCount` increments (saturating) and the checker reseeds from the received word.
  - The seed persists across bursts, so the ramp must be continuous between bursts.
- Macro undefined: no checker logic is built. `errorCount` is tied to 0; all other behaviour is identical.

## Test plan
- Reset, then `enable`=1, `dataAvailable`=1, ramp source starting at 0x03FE, `BURST_WORDS`=16 -> `readData` high for exactly 16 cycles. `wordOut` sequence is 0x03FE, 0x03FF, 0x0000, ... 0x000D. One `burstDone`, `burstCount`=1, `errorCount`=0.
- `dataAvailable` held at 0 for 50 cycles in ARM -> `readData` stays 0. Raise it -> READ begins 1 cycle later.
- Ramp source with word 5 forced to 0x0123 -> `errorCount`=2 (the bad word, then the first word after resume, which is ramp+1 mismatched against the reseed 0x0124). With the macro undefined, `errorCount`=0.
- `bufferError` pulsed for 1 cycle during GAP -> `overflowSeen`=1 and stays 1 through 3 further bursts.
- `nReset` asserted on read cycle 7 of a burst -> all outputs return to reset values immediately. After release, a full 16-word burst completes with `burstCount`=1.
- `enable` dropped on read cycle 3 -> the burst completes all 16 words, `burstDone` pulses, and the FSM returns to IDLE after GAP with no further `readData`.

Source files
------------

// File: rtl/gpif_burst_reader.sv
// FX3-side GPIF burst consumer: reads fixed-length bursts when the producer has data and captures the words.
// Optional ramp checker built when GPIF_READER_CHECK_EN is defined; otherwise errorCount is tied to zero.
module gpif_burst_reader #(
  parameter int BURST_WORDS  = 8192,
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        enable,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic [15:0] databus,
  output logic        readData,
  output logic        wordValid,
  output logic [15:0] wordOut,
  output logic        burstDone,
  output logic [15:0] burstCount,
  output logic [15:0] errorCount,
  output logic        overflowSeen
);

  localparam int RW = $clog2(BURST_WORDS) + 1;
  localparam int CW = $clog2(BURST_WORDS);
  localparam logic [RW-1:0] RD_LAST    = RW'(BURST_WORDS - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(BURST_WORDS - 1);
  localparam logic [7:0]    DRAIN_LAST = 8'(READ_LATENCY - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, READ, DRAIN, GAP} state_t;

  state_t                  state, next_state;
  logic [RW-1:0]           rd_cnt;
  logic [7:0]              phase_cnt;
  logic [READ_LATENCY-1:0] rd_vld_pipe;
  logic [CW-1:0]           cap_cnt;
  logic                    cap_vld_p0;

  // Word on databus is valid exactly when readData was high READ_LATENCY cycles ago.
  assign cap_vld_p0 = rd_vld_pipe[READ_LATENCY-1];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enable) next_state = ARM;
      ARM: begin
        if (!enable)            next_state = IDLE;
        else if (dataAvailable) next_state = READ;
      end
      READ:  if (rd_cnt == RD_LAST) next_state = DRAIN;
      DRAIN: if (phase_cnt == DRAIN_LAST) next_state = GAP;
      GAP:   if (phase_cnt == GAP_LAST) next_state = enable ? ARM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read strobe is registered from next_state so it is high for exactly the READ cycles.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      readData  <= 1'b0;
      rd_cnt    <= '0;
      phase_cnt <= 8'd0;
    end else begin
      readData  <= (next_state == READ);
      rd_cnt    <= (state == READ) ? rd_cnt + 1'b1 : '0;
      phase_cnt <= ((state == DRAIN || state == GAP) && next_state == state) ?
                   phase_cnt + 8'd1 : 8'd0;
    end
  end

  // ---- stage p0 -> p1: capture qualified databus word ----
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rd_vld_pipe  <= '0;
      wordOut      <= 16'h0000;
      wordValid    <= 1'b0;
      burstDone    <= 1'b0;
      cap_cnt      <= '0;
      burstCount   <= 16'h0000;
      overflowSeen <= 1'b0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) rd_vld_pipe[i] <= rd_vld_pipe[i-1];
      rd_vld_pipe[0] <= readData;
      wordValid      <= cap_vld_p0;
      burstDone      <= cap_vld_p0 && (cap_cnt == CAP_LAST);
      overflowSeen   <= overflowSeen | bufferError;
      if (cap_vld_p0) begin
        wordOut <= databus;
        cap_cnt <= cap_cnt + 1'b1;
        if (cap_cnt == CAP_LAST) burstCount <= burstCount + 16'd1;
      end
    end
  end

`ifdef GPIF_READER_CHECK_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic       seeded;
  logic [9:0] expected;

  // Checker runs on the same edge as the capture so errors land with their burst's burstDone.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      seeded     <= 1'b0;
      expected   <= 10'd0;
      errorCount <= 16'h0000;
    end else if (cap_vld_p0) begin
      if (!seeded) begin
        seeded   <= 1'b1;
        expected <= databus[9:0] + 10'd1;
      end else if (databus != {6'b0, expected}) begin
        errorCount <= sat_inc16(errorCount);
        expected   <= databus[9:0] + 10'd1;
      end else begin
        expected <= expected + 10'd1;
      end
    end
  end
`else
  assign errorCount = 16'h0000;
`endif

endmodule

// File: tb/tb_gpif_burst_reader.sv
// Directed bench for gpif_burst_reader: ramp producer model, stall, error injection, overflow, reset and enable drop.
module tb_gpif_burst_reader;

  localparam int BW = 16;
  localparam int RL = 2;
  localparam int GC = 4;
`ifdef GPIF_READER_CHECK_EN
  localparam int ERR_EXP = 2;
`else
  localparam int ERR_EXP = 0;
`endif

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0;
  logic        dataAvailable = 1'b0;
  logic        bufferError = 1'b0;
  logic [15:0] databus = 16'h0000;
  logic        readData;
  logic        wordValid;
  logic [15:0] wordOut;
  logic        burstDone;
  logic [15:0] burstCount;
  logic [15:0] errorCount;
  logic        overflowSeen;

  always #5 clock = ~clock;

  gpif_burst_reader #(
    .BURST_WORDS (BW),
    .READ_LATENCY(RL),
    .GAP_CYCLES  (GC)
  ) dut (
    .clock        (clock),
    .nReset       (nReset),
    .enable       (enable),
    .dataAvailable(dataAvailable),
    .bufferError  (bufferError),
    .databus      (databus),
    .readData     (readData),
    .wordValid    (wordValid),
    .wordOut      (wordOut),
    .burstDone    (burstDone),
    .burstCount   (burstCount),
    .errorCount   (errorCount),
    .overflowSeen (overflowSeen)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ramp producer: a readData-high cycle puts its word on databus RL cycles later.
  logic [9:0]  src = 10'h3FE;
  int          src_idx = 0;
  int          force_idx = -1;
  logic [15:0] q [RL] = '{default: 16'h0000};

  always @(negedge clock) begin
    databus = q[RL-1];
    for (int i = RL - 1; i > 0; i--) q[i] = q[i-1];
    if (readData) begin
      q[0] = (src_idx == force_idx) ? 16'h0123 : {6'b0, src};
      src = src + 10'd1;
      src_idx++;
    end else begin
      q[0] = 16'h0000;
    end
  end

  int          rd_total = 0;
  int          done_total = 0;
  int          wv_total = 0;
  logic [15:0] words [1024];

  always @(negedge clock) begin
    if (readData) rd_total++;
    if (burstDone) done_total++;
    if (wordValid) begin
      words[wv_total % 1024] = wordOut;
      wv_total++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int max_cyc);
    bit found = 1'b0;
    for (int k = 0; k < max_cyc && !found; k++) begin
      tick();
      if (burstDone) found = 1'b1;
    end
    if (!found) check_val("done_timeout", 0, 1);
    else        check_val("done_with_valid", wordValid, 1);
    tick();
  endtask

  task automatic wait_read(input int max_cyc);
    bit found = 1'b0;
    for (int k = 0; k < max_cyc && !found; k++) begin
      tick();
      if (readData) found = 1'b1;
    end
    if (!found) check_val("read_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_readData"}, readData, 0);
    check_val({tag, "_wordValid"}, wordValid, 0);
    check_val({tag, "_wordOut"}, wordOut, 0);
    check_val({tag, "_burstDone"}, burstDone, 0);
    check_val({tag, "_burstCount"}, burstCount, 0);
    check_val({tag, "_errorCount"}, errorCount, 0);
    check_val({tag, "_overflowSeen"}, overflowSeen, 0);
  endtask

  int         base_rd;
  int         base_w;
  int         base_d;
  logic [9:0] s0;
  logic [9:0] e10;

  initial begin
    repeat (3) tick();
    check_reset_outputs("rst");

    // Basic burst with ramp wrapping through 0x3FF -> 0x000
    enable = 1'b1;
    dataAvailable = 1'b1;
    base_rd = rd_total;
    base_w = wv_total;
    base_d = done_total;
    nReset = 1'b1;
    tick();
    check_val("arm_no_read", readData, 0);
    tick();
    check_val("first_read", readData, 1);
    wait_done(60);
    enable = 1'b0;
    check_val("t1_read_cycles", rd_total - base_rd, BW);
    check_val("t1_done_pulses", done_total - base_d, 1);
    for (int i = 0; i < BW; i++) begin
      e10 = 10'h3FE + 10'(i);
      check_val("t1_word", words[(base_w + i) % 1024], {6'b0, e10});
    end
    check_val("t1_burstCount", burstCount, 1);
    check_val("t1_errorCount", errorCount, 0);
    repeat (8) tick();

    // ARM stall while dataAvailable is low
    dataAvailable = 1'b0;
    enable = 1'b1;
    base_rd = rd_total;
    repeat (50) tick();
    check_val("stall_no_read", rd_total - base_rd, 0);
    dataAvailable = 1'b1;
    tick();
    check_val("resume_read", readData, 1);
    wait_done(60);
    enable = 1'b0;
    check_val("t2_burstCount", burstCount, 2);
    repeat (8) tick();

    // Corrupted word 5
    force_idx = src_idx + 5;
    s0 = src;
    base_w = wv_total;
    enable = 1'b1;
    wait_done(60);
    enable = 1'b0;
    check_val("t3_bad_word", words[(base_w + 5) % 1024], 16'h0123);
    e10 = s0 + 10'd6;
    check_val("t3_after_bad", words[(base_w + 6) % 1024], {6'b0, e10});
    check_val("t3_errorCount", errorCount, ERR_EXP);
    check_val("t3_burstCount", burstCount, 3);
    repeat (8) tick();

    // Overflow pulse during GAP stays sticky over further bursts
    enable = 1'b1;
    wait_done(60);
    bufferError = 1'b1;
    tick();
    bufferError = 1'b0;
    check_val("ovf_set", overflowSeen, 1);
    for (int b = 0; b < 3; b++) begin
      wait_done(60);
      check_val("ovf_sticky", overflowSeen, 1);
    end
    enable = 1'b0;
    check_val("t4_burstCount", burstCount, 7);
    check_val("t4_errorCount", errorCount, ERR_EXP);
    repeat (8) tick();

    // Asynchronous reset on read cycle 7
    enable = 1'b1;
    wait_read(20);
    repeat (6) tick();
    check_val("rc7_reading", readData, 1);
    nReset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    base_rd = rd_total;
    nReset = 1'b1;
    wait_done(60);
    enable = 1'b0;
    check_val("t5_burstCount", burstCount, 1);
    check_val("t5_errorCount", errorCount, 0);
    check_val("t5_read_cycles", rd_total - base_rd, BW);
    repeat (8) tick();

    // enable dropped on read cycle 3
    enable = 1'b1;
    base_rd = rd_total;
    base_d = done_total;
    wait_read(20);
    tick();
    tick();
    enable = 1'b0;
    wait_done(60);
    check_val("t6_read_cycles", rd_total - base_rd, BW);
    check_val("t6_done_pulses", done_total - base_d, 1);
    check_val("t6_burstCount", burstCount, 2);
    repeat (30) tick();
    check_val("t6_no_more_read", rd_total - base_rd, BW);
    check_val("t6_idle_read", readData, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
